// File: rtl/fast_sweep_sequencer_if.sv
// Settings-side control/status bundle for fast_sweep_sequencer.
// The master drives the configuration and strobes; the slave (sequencer) reports status.
interface fast_sweep_sequencer_if #(
  parameter int unsigned MAX_STEPS = 64,
  parameter int unsigned TICK_W    = 20
);
  localparam int unsigned SW = (MAX_STEPS > 1) ? $clog2(MAX_STEPS) : 1;
  localparam int unsigned NW = SW + 1;

  logic              start;
  logic              continuous;
  logic              abort;
  logic [NW-1:0]     num_steps;
  logic [TICK_W-1:0] settle_ticks;
  logic [TICK_W-1:0] record_ticks;
  logic              busy;
  logic [SW-1:0]     step_index;
  logic [15:0]       sweep_count;
  logic              lock_err;
  logic [7:0]        relock_cnt;
  logic [2:0]        state_dbg;

  modport master (
    output start, continuous, abort, num_steps, settle_ticks, record_ticks,
    input  busy, step_index, sweep_count, lock_err, relock_cnt, state_dbg
  );

  modport slave (
    input  start, continuous, abort, num_steps, settle_ticks, record_ticks,
    output busy, step_index, sweep_count, lock_err, relock_cnt, state_dbg
  );
endinterface

// File: rtl/fast_sweep_sequencer.sv
// Frequency-sweep sequencer: steps an external synthesizer and gates the fast-square
// RX datapath per step, with lock timeout/skip and re-record on lock loss.
module fast_sweep_sequencer #(
  parameter int unsigned MAX_STEPS    = 64,
  parameter int unsigned TICK_W       = 20,
  parameter int unsigned PULSE_TICKS  = 4,
  parameter int unsigned LOCK_TIMEOUT = 65535
) (
  input  logic                   clock,
  input  logic                   reset_n,
  fast_sweep_sequencer_if.slave  ctl,
  input  logic                   pll_locked,
  output logic                   freq_step_reset_out,
  output logic                   freq_step_out,
  output logic                   rx_reset,
  output logic                   rx_next,
  output logic                   rx_record
);
  localparam int unsigned SW = (MAX_STEPS > 1) ? $clog2(MAX_STEPS) : 1;
  localparam int unsigned NW = SW + 1;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    RESET_SYN = 3'd1,
    WAIT_LOCK = 3'd2,
    SETTLE    = 3'd3,
    RECORD    = 3'd4,
    STEP      = 3'd5
  } state_t;

  state_t            state_q;
  logic              rst_meta_q, rst_n_s;
  logic              lock_meta_q, lock_s_q;
  logic [TICK_W-1:0] cnt_q, settle_q, rec_q;
  logic [SW-1:0]     last_q, step_q;
  logic [15:0]       sweep_q;
  logic [7:0]        relock_q;
  logic              lock_err_q, busy_q;
  logic              fsr_q, fso_q, rx_reset_q, rx_next_q, rx_record_q;

  logic [SW-1:0]     last_idx;
  logic              is_last, pulse_done, settle_done, rec_done, lock_to;

  // Reset asserts asynchronously but releases on a clock edge.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rst_meta_q <= 1'b0;
      rst_n_s    <= 1'b0;
    end else begin
      rst_meta_q <= 1'b1;
      rst_n_s    <= rst_meta_q;
    end
  end

  always_ff @(posedge clock or negedge rst_n_s) begin
    if (!rst_n_s) begin
      lock_meta_q <= 1'b0;
      lock_s_q    <= 1'b0;
    end else begin
      lock_meta_q <= pll_locked;
      lock_s_q    <= lock_meta_q;
    end
  end

  always_comb begin
    last_idx = '0;
    if (ctl.num_steps == '0)
      last_idx = '0;
    else if (ctl.num_steps > NW'(MAX_STEPS))
      last_idx = SW'(MAX_STEPS - 1);
    else
      last_idx = SW'(ctl.num_steps - 1'b1);
  end

  assign is_last     = (step_q == last_q);
  assign pulse_done  = (cnt_q == TICK_W'(PULSE_TICKS - 1));
  assign settle_done = (settle_q == '0) || (cnt_q == settle_q - 1'b1);
  assign rec_done    = (cnt_q == rec_q - 1'b1);
  assign lock_to     = (cnt_q == TICK_W'(LOCK_TIMEOUT - 1));

  always_ff @(posedge clock or negedge rst_n_s) begin
    if (!rst_n_s) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      settle_q    <= '0;
      rec_q       <= TICK_W'(1);
      last_q      <= '0;
      step_q      <= '0;
      sweep_q     <= '0;
      relock_q    <= '0;
      lock_err_q  <= 1'b0;
      busy_q      <= 1'b0;
      fsr_q       <= 1'b0;
      fso_q       <= 1'b0;
      rx_reset_q  <= 1'b1;
      rx_next_q   <= 1'b0;
      rx_record_q <= 1'b0;
    end else begin
      rx_next_q <= 1'b0;
      if (ctl.abort) begin
        state_q     <= IDLE;
        cnt_q       <= '0;
        step_q      <= '0;
        busy_q      <= 1'b0;
        fsr_q       <= 1'b0;
        fso_q       <= 1'b0;
        rx_reset_q  <= 1'b1;
        rx_record_q <= 1'b0;
      end else begin
        case (state_q)
          IDLE: if (ctl.start) begin
            settle_q   <= ctl.settle_ticks;
            rec_q      <= (ctl.record_ticks == '0) ? TICK_W'(1) : ctl.record_ticks;
            last_q     <= last_idx;
            lock_err_q <= 1'b0;
            relock_q   <= '0;
            step_q     <= '0;
            cnt_q      <= '0;
            busy_q     <= 1'b1;
            fsr_q      <= 1'b1;
            state_q    <= RESET_SYN;
          end
          RESET_SYN: begin
            if (pulse_done) begin
              fsr_q      <= 1'b0;
              rx_reset_q <= 1'b0;
              cnt_q      <= '0;
              state_q    <= WAIT_LOCK;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
          WAIT_LOCK: begin
            if (lock_s_q) begin
              cnt_q   <= '0;
              state_q <= SETTLE;
            end else if (lock_to) begin
              // Skipped step still advances through STEP so the bin count stays aligned.
              lock_err_q <= 1'b1;
              rx_next_q  <= 1'b1;
              fso_q      <= !is_last;
              cnt_q      <= '0;
              state_q    <= STEP;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
          SETTLE: begin
            if (!lock_s_q) begin
              cnt_q   <= '0;
              state_q <= WAIT_LOCK;
            end else if (settle_done) begin
              cnt_q       <= '0;
              rx_record_q <= 1'b1;
              state_q     <= RECORD;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
          RECORD: begin
            if (!lock_s_q) begin
              rx_record_q <= 1'b0;
              if (relock_q != 8'hFF) relock_q <= relock_q + 8'd1;
              cnt_q   <= '0;
              state_q <= WAIT_LOCK;
            end else if (rec_done) begin
              rx_record_q <= 1'b0;
              rx_next_q   <= 1'b1;
              fso_q       <= !is_last;
              cnt_q       <= '0;
              state_q     <= STEP;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
          STEP: begin
            if (!is_last) begin
              if (pulse_done) begin
                fso_q   <= 1'b0;
                step_q  <= step_q + 1'b1;
                cnt_q   <= '0;
                state_q <= WAIT_LOCK;
              end else begin
                cnt_q <= cnt_q + 1'b1;
              end
            end else begin
              sweep_q    <= sweep_q + 16'd1;
              cnt_q      <= '0;
              rx_reset_q <= 1'b1;
              if (ctl.continuous) begin
                step_q  <= '0;
                fsr_q   <= 1'b1;
                state_q <= RESET_SYN;
              end else begin
                busy_q  <= 1'b0;
                state_q <= IDLE;
              end
            end
          end
          default: begin
            state_q    <= IDLE;
            busy_q     <= 1'b0;
            rx_reset_q <= 1'b1;
          end
        endcase
      end
    end
  end

  assign freq_step_reset_out = fsr_q;
  assign freq_step_out       = fso_q;
  assign rx_reset            = rx_reset_q;
  assign rx_next             = rx_next_q;
  assign rx_record           = rx_record_q;
  assign ctl.busy            = busy_q;
  assign ctl.step_index      = step_q;
  assign ctl.sweep_count     = sweep_q;
  assign ctl.lock_err        = lock_err_q;
  assign ctl.relock_cnt      = relock_q;
  assign ctl.state_dbg       = state_q;
endmodule
